fft_frame_ctrl: RTL and testbench

Frame sequencer for the 4-lane parallel FFT core (`topfft`). It accepts a valid/ready stream of 4-sample beats and drives the four complex FFT input lanes on contiguous N/4-beat frames. A mid-frame underrun is zero-padded and flagged. A tag delay line matched to the core latency produces output-side valid, start-of-frame and end-of-frame markers aligned with `fftOut*`.

---
 rtl/fft_ctrl_pkg.sv | 28 ++
 rtl/fft_tag_delay.sv | 41 ++++
 rtl/fft_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and size derivations for the FFT frame sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    localparam int TAG_W = 4;

    // vld is the MSB so the delay line can OR it without unpacking
    typedef struct packed {
        logic vld;
        logic sof;
        logic eof;
        logic err;
    } tag_t;

    function automatic int beats_of(input int n);
        return n / 4;
    endfunction

    function automatic int cnt_w_of(input int n);
        return (n / 4 > 1) ? $clog2(n / 4) : 1;
    endfunction

endpackage

// File: rtl/fft_tag_delay.sv
// LAT-deep tag shift register matched to the FFT core latency, with an
// any-valid summary so the controller knows when the pipe has drained.
module fft_tag_delay
    import fft_ctrl_pkg::*;
#(
    parameter int LAT = 12
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    logic [TAG_W-1:0] pipe_r [LAT];

    // tag shift register, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // OR of the valid bit across every stage
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_valid = any_valid | pipe_r[i][TAG_W-1];
        end
    end

    assign tag_out = pipe_r[LAT-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 4-lane FFT core: turns a valid/ready beat stream into
// contiguous N/4-beat frames, zero-pads underruns and emits latency-aligned tags.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NBITS = 10,
    parameter int N     = 128,
    parameter int LAT   = 12,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*NBITS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*NBITS-1:0] fftIn0_up,
    output logic [2*NBITS-1:0] fftIn0_down,
    output logic [2*NBITS-1:0] fftIn1_up,
    output logic [2*NBITS-1:0] fftIn1_down,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    output logic               out_err,
    output logic               err_sticky,
    input  logic               clr_err,
    output logic [CNTW-1:0]    frame_cnt,
    output logic               busy
);

    localparam int BEATS = beats_of(N);
    localparam int CW    = cnt_w_of(N);
    localparam int LW    = 2 * NBITS;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nxt_s;
    logic               ferr_r;
    logic               ferr_nxt_s;
    logic               take_s;
    logic               beat_s;
    logic               under_s;
    logic               sof_s;
    logic               eof_s;
    tag_t               tag_nxt_s;
    tag_t               tag_r;
    tag_t               tag_out_s;
    logic               any_vld_s;
    logic [8*NBITS-1:0] lanes_r;
    logic               err_sticky_r;
    logic [CNTW-1:0]    frame_cnt_r;

    // state, beat counter and frame error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ferr_r  <= ferr_nxt_s;
        end
    end

    // next state, beat decode and tag for the beat driven this cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ferr_nxt_s  = ferr_r;
        take_s      = 1'b0;
        beat_s      = 1'b0;
        under_s     = 1'b0;
        sof_s       = 1'b0;
        eof_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    take_s      = 1'b1;
                    beat_s      = 1'b1;
                    sof_s       = 1'b1;
                    cnt_nxt_s   = CW'(1);
                    ferr_nxt_s  = 1'b0;
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                beat_s     = 1'b1;
                take_s     = in_valid;
                under_s    = !in_valid;
                ferr_nxt_s = ferr_r | !in_valid;
                // an underrun on the last beat closes the frame without visiting PAD
                if (cnt_r == LAST_BEAT) begin
                    eof_s       = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                    state_nxt_s = in_valid ? ST_RUN : ST_PAD;
                end
            end
            ST_PAD: begin
                beat_s     = 1'b1;
                ferr_nxt_s = 1'b1;
                if (cnt_r == LAST_BEAT) begin
                    eof_s       = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                    state_nxt_s = ST_PAD;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                ferr_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
        // ferr may be stale from the previous frame on its first beat
        tag_nxt_s.vld = beat_s;
        tag_nxt_s.sof = sof_s;
        tag_nxt_s.eof = eof_s;
        tag_nxt_s.err = beat_s & (under_s | (ferr_r & !sof_s));
    end

    // core input lanes and the tag launched alongside them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_r <= '0;
            tag_r   <= '0;
        end else begin
            lanes_r <= take_s ? in_data : '0;
            tag_r   <= tag_nxt_s;
        end
    end

    // sticky underrun flag (set beats clear) and completed-frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            if (under_s) begin
                err_sticky_r <= 1'b1;
            end else if (clr_err) begin
                err_sticky_r <= 1'b0;
            end else begin
                err_sticky_r <= err_sticky_r;
            end
            if (tag_out_s.eof) begin
                frame_cnt_r <= frame_cnt_r + CNTW'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    fft_tag_delay #(
        .LAT (LAT)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_r),
        .tag_out   (tag_out_s),
        .any_valid (any_vld_s)
    );

    assign in_ready    = (state_r != ST_PAD) && !rst;
    assign fftIn0_up   = lanes_r[LW-1:0];
    assign fftIn0_down = lanes_r[2*LW-1:LW];
    assign fftIn1_up   = lanes_r[3*LW-1:2*LW];
    assign fftIn1_down = lanes_r[4*LW-1:3*LW];
    assign out_valid   = tag_out_s.vld;
    assign out_sof     = tag_out_s.sof;
    assign out_eof     = tag_out_s.eof;
    assign out_err     = tag_out_s.err;
    assign err_sticky  = err_sticky_r;
    assign frame_cnt   = frame_cnt_r;
    assign busy        = (state_r != ST_IDLE) || tag_r.vld || any_vld_s;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: per-cycle scoreboard model plus
// hand-computed literal checks, and a small second instance for counter wrap.
module tb_fft_frame_ctrl;

    localparam int NBITS = 10;
    localparam int N     = 128;
    localparam int LAT   = 12;
    localparam int CNTW  = 16;
    localparam int BEATS = N / 4;
    localparam int RL    = 32;
    localparam int LW    = 2 * NBITS;
    localparam int DW    = 8 * NBITS;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          clr_err  = 1'b0;
    logic          in_ready;
    logic [LW-1:0] f0u, f0d, f1u, f1d;
    logic          out_valid, out_sof, out_eof, out_err, err_sticky, busy;
    logic [CNTW-1:0] frame_cnt;

    logic [DW-1:0] b_data  = '0;
    logic          b_valid = 1'b0;
    logic          b_clr   = 1'b0;
    logic          b_ready;
    logic [LW-1:0] b0u, b0d, b1u, b1d;
    logic          b_ovalid, b_osof, b_oeof, b_oerr, b_sticky, b_busy;
    logic [3:0]    b_cnt;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.NBITS(NBITS), .N(N), .LAT(LAT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fftIn0_up(f0u), .fftIn0_down(f0d), .fftIn1_up(f1u), .fftIn1_down(f1d),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
        .err_sticky(err_sticky), .clr_err(clr_err), .frame_cnt(frame_cnt), .busy(busy)
    );

    fft_frame_ctrl #(.NBITS(NBITS), .N(8), .LAT(2), .CNTW(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .fftIn0_up(b0u), .fftIn0_down(b0d), .fftIn1_up(b1u), .fftIn1_down(b1d),
        .out_valid(b_ovalid), .out_sof(b_osof), .out_eof(b_oeof), .out_err(b_oerr),
        .err_sticky(b_sticky), .clr_err(b_clr), .frame_cnt(b_cnt), .busy(b_busy)
    );

    int tests = 0;
    int fails = 0;

    // frame-level model: beat position in frame, padding mode, and a ring of
    // expected output tags indexed by the cycle they must appear on
    int              c        = 0;
    int              m_pos    = -1;
    bit              m_pad    = 1'b0;
    bit              m_ferr   = 1'b0;
    bit              m_sticky = 1'b0;
    logic [CNTW-1:0] m_frames = '0;
    logic [DW-1:0]   e_lanes  = '0;
    logic [3:0]      r_tag [RL];

    function automatic logic [DW-1:0] mk(input int i);
        logic [LW-1:0] l0, l1, l2, l3;
        l0 = LW'(i);
        l1 = LW'(i + 100);
        l2 = LW'(i + 200);
        l3 = LW'(i + 300);
        return {l3, l2, l1, l0};
    endfunction

    always @(posedge clk) begin : model
        int idx, np;
        bit drv, tk, pad, und, sof, eof, err, npad, nferr;
        if (rst) begin
            c        <= 0;
            m_pos    <= -1;
            m_pad    <= 1'b0;
            m_ferr   <= 1'b0;
            m_sticky <= 1'b0;
            m_frames <= '0;
            e_lanes  <= '0;
            for (int i = 0; i < RL; i++) r_tag[i] <= 4'b0000;
        end else begin
            drv = 1'b0; tk = 1'b0; pad = 1'b0; und = 1'b0;
            sof = 1'b0; eof = 1'b0; err = 1'b0; idx = 0;
            np = m_pos; npad = m_pad; nferr = m_ferr;
            if (m_pos < 0) begin
                if (in_valid) begin
                    drv = 1'b1; tk = 1'b1; sof = 1'b1; nferr = 1'b0;
                end
            end else begin
                drv = 1'b1;
                idx = m_pos;
                pad = m_pad || !in_valid;
                und = !m_pad && !in_valid;
                tk  = !pad;
                err = m_ferr || pad;
                if (pad) nferr = 1'b1;
            end
            if (drv) begin
                eof  = (idx == BEATS - 1);
                np   = eof ? -1 : idx + 1;
                npad = eof ? 1'b0 : pad;
            end
            if (r_tag[c % RL][1]) m_frames <= m_frames + 16'd1;
            r_tag[(c + 1 + LAT) % RL] <= {drv, sof, eof, err};
            c       <= c + 1;
            e_lanes <= tk ? in_data : '0;
            m_pos   <= np;
            m_pad   <= npad;
            m_ferr  <= nferr;
            if (und) m_sticky <= 1'b1;
            else if (clr_err) m_sticky <= 1'b0;
        end
    end

    // literal-check mailbox: stimulus posts, compare process evaluates
    int          lit_seq  = 0;
    int          lit_done = 0;
    int          lit_code = 0;
    logic [95:0] lit_exp  = '0;
    string       lit_name = "";
    int          acc_c    = 0;
    int          base_e   = 0;
    int          base_v   = 0;

    int          max_run  = 0;
    int          run_len  = 0;
    int          err_cnt  = 0;
    int          vld_cnt  = 0;
    int          sof_c    = 0;
    logic [63:0] sof_mask = '0;
    logic [63:0] eof_mask = '0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, c);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [3:0]  et;
        logic        eb;
        logic [95:0] act;
        et = rst ? 4'b0000 : r_tag[c % RL];
        eb = 1'b0;
        if (!rst) begin
            eb = (m_pos >= 0);
            for (int k = 0; k <= LAT; k++) if (r_tag[(c + k) % RL][3]) eb = 1'b1;
        end
        chk("in_ready", 96'(in_ready), rst ? 96'd0 : 96'(!(m_pos >= 0 && m_pad)));
        chk("lanes", 96'({f1d, f1u, f0d, f0u}), rst ? 96'd0 : 96'(e_lanes));
        chk("tags", 96'({out_valid, out_sof, out_eof, out_err}), 96'(et));
        chk("err_sticky", 96'(err_sticky), rst ? 96'd0 : 96'(m_sticky));
        chk("frame_cnt", 96'(frame_cnt), rst ? 96'd0 : 96'(m_frames));
        chk("busy", 96'(busy), 96'(eb));

        if (out_valid) begin
            if (out_sof && run_len < 64) sof_mask[run_len] = 1'b1;
            if (out_eof && run_len < 64) eof_mask[run_len] = 1'b1;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            vld_cnt++;
            if (out_err) err_cnt++;
        end else begin
            run_len = 0;
        end
        if (out_sof) sof_c = c;

        if (lit_seq != lit_done) begin
            case (lit_code)
                1:  act = 96'(frame_cnt);
                2:  act = 96'(err_sticky);
                3:  act = 96'(max_run);
                4:  act = 96'(sof_mask);
                5:  act = 96'(eof_mask);
                6:  act = 96'(f0u);
                7:  act = 96'(sof_c - acc_c);
                8:  act = 96'(err_cnt - base_e);
                9:  act = 96'(vld_cnt - base_v);
                10: act = 96'({out_valid, out_sof, out_eof, out_err, busy, in_ready, |{f1d, f1u, f0d, f0u}});
                11: act = 96'(b_cnt);
                12: act = 96'({b_ovalid, b_osof, b_oeof, b_oerr, b_sticky, b_busy, |{b1d, b1u, b0d, b0u}, b_ready});
                default: act = '1;
            endcase
            chk(lit_name, act, lit_exp);
            lit_done = lit_seq;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic ce);
        in_valid = v;
        in_data  = d;
        clr_err  = ce;
        @(posedge clk);
        #2;
    endtask

    task automatic post(input int code, input string nm, input logic [95:0] exp);
        lit_code = code;
        lit_name = nm;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (LAT + 4) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        post(10, "ready_after_reset", 96'd2);

        // two back-to-back frames
        for (int i = 0; i < 2 * BEATS; i++) step(1'b1, mk(i), 1'b0);
        drain();
        post(1, "two_frames_cnt", 96'd2);
        post(2, "clean_sticky", 96'd0);
        post(3, "valid_run_len", 96'd64);
        post(4, "sof_beats_0_32", (96'd1 << 32) | 96'd1);
        post(5, "eof_beats_31_63", (96'd1 << 63) | (96'd1 << 31));

        // single frame: lane timing and output latency
        step(1'b1, mk(0), 1'b0);
        acc_c = c;
        post(6, "lane0_beat0", 96'd0);
        for (int i = 1; i < BEATS; i++) begin
            step(1'b1, mk(i), 1'b0);
            if (i == 5) post(6, "lane0_beat5", 96'd5);
        end
        drain();
        post(7, "sof_latency", 96'(LAT));

        // underrun at beat 10; upstream keeps offering data while padded
        base_e = err_cnt;
        base_v = vld_cnt;
        for (int i = 0; i < 10; i++) step(1'b1, mk(i), 1'b0);
        step(1'b0, mk(10), 1'b0);
        for (int i = 11; i < BEATS; i++) step(1'b1, mk(i), 1'b0);
        drain();
        post(8, "underrun_err_beats", 96'd22);
        post(9, "underrun_frame_len", 96'd32);
        post(2, "underrun_sticky", 96'd1);
        step(1'b0, '0, 1'b1);
        post(2, "clr_sticky", 96'd0);

        // clean frame after an errored one
        base_e = err_cnt;
        for (int i = 0; i < BEATS; i++) step(1'b1, mk(i + 40), 1'b0);
        drain();
        post(8, "clean_err_beats", 96'd0);

        // underrun on the last beat coinciding with clr_err
        for (int i = 0; i < BEATS - 1; i++) step(1'b1, mk(i), 1'b0);
        step(1'b0, mk(31), 1'b1);
        post(2, "set_beats_clear", 96'd1);
        step(1'b0, '0, 1'b1);
        post(2, "clear_alone", 96'd0);
        drain();

        // reset in the middle of a frame
        for (int i = 0; i < 20; i++) step(1'b1, mk(i), 1'b0);
        in_valid = 1'b1;
        in_data  = mk(20);
        rst      = 1'b1;
        post(10, "rst_midframe_zero", 96'd0);
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        base_v = vld_cnt;
        repeat (LAT + 6) step(1'b0, '0, 1'b0);
        post(9, "no_tags_after_rst", 96'd0);
        for (int i = 0; i < BEATS; i++) step(1'b1, mk(i), 1'b0);
        drain();
        post(1, "cnt_after_rst", 96'd1);

        // 4-bit counter wraps after 17 frames of 2 beats
        for (int i = 0; i < 34; i++) begin
            b_valid = 1'b1;
            b_data  = mk(i);
            @(posedge clk);
            #2;
        end
        b_valid = 1'b0;
        b_data  = '0;
        repeat (8) @(posedge clk);
        #2;
        post(11, "wrap_cnt", 96'd1);
        post(12, "wrap_idle", 96'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
